acc_unit: RTL and testbench

- Parametrised accumulator for the RISC datapath.
- Adds in-place unary ALU ops (inc/dec/shift/rotate), a carry flag, combinational zero/negative flags, and a DEPTH-entry save/restore stack for the accumulator value.
- Sits between the ALU result bus and the operand-A mux. Controlled by the control unit with one opcode per cycle.

---
 rtl/acc_unit.sv | 171 +++++++++++++++++
 tb/tb_acc_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_unit.sv
// Accumulator with in-place unary ALU ops, carry/zero/negative flags and a
// small LIFO save/restore stack for the accumulator value.
module acc_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [3:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       carry,
  output logic                       zero,
  output logic                       neg,
  output logic [$clog2(DEPTH+1)-1:0] stk_count,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Stack address width; storage is rounded up to a power of two so the
  // truncated count can index it without width games.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpLoad = 4'd1,
    OpClr  = 4'd2,
    OpInc  = 4'd3,
    OpDec  = 4'd4,
    OpShl  = 4'd5,
    OpShr  = 4'd6,
    OpRol  = 4'd7,
    OpRor  = 4'd8,
    OpPush = 4'd9,
    OpPop  = 4'd10,
    OpSwap = 4'd11
  } op_e;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set;

  logic [WIDTH-1:0] stack_q [2**AW];
  logic             stk_we;
  logic [AW-1:0]    stk_widx;
  logic [WIDTH-1:0] stk_wdata;

  logic [CW-1:0]    top_cnt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic [WIDTH-1:0] top_val;
  logic             full;
  logic             empty;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_cnt  = cnt_q - CW'(1);
  assign top_idx  = top_cnt[AW-1:0];
  assign push_idx = cnt_q[AW-1:0];
  assign top_val  = stack_q[top_idx];

  always_comb begin
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    err_set   = 1'b0;
    stk_we    = 1'b0;
    stk_widx  = push_idx;
    stk_wdata = acc_q;
    if (en) begin
      case (op_e'(op))
        OpLoad: acc_d = data_in;
        OpClr: begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
        OpInc: {carry_d, acc_d} = {1'b0, acc_q} + (WIDTH + 1)'(1);
        OpDec: begin
          carry_d = (acc_q == '0);
          acc_d   = acc_q - WIDTH'(1);
        end
        OpShl: begin
          carry_d = acc_q[WIDTH-1];
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
        end
        OpShr: begin
          carry_d = acc_q[0];
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
        end
        OpRol: begin
          carry_d = acc_q[WIDTH-1];
          acc_d   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        end
        OpRor: begin
          carry_d = acc_q[0];
          acc_d   = {acc_q[0], acc_q[WIDTH-1:1]};
        end
        OpPush: begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            stk_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        OpPop: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            acc_d = top_val;
            cnt_d = top_cnt;
          end
        end
        OpSwap: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            acc_d    = top_val;
            stk_we   = 1'b1;
            stk_widx = top_idx;
          end
        end
        default: ;
      endcase
    end
    // A new error outranks a simultaneous clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stk_we) begin
      stack_q[stk_widx] <= stk_wdata;
    end
  end

  assign data_out  = acc_q;
  assign carry     = carry_q;
  assign zero      = (acc_q == '0);
  assign neg       = acc_q[WIDTH-1];
  assign stk_count = cnt_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit: directed plan sequences plus random ops,
// checked against an arithmetic reference model with a queue-based stack.
module tb_acc_unit;

  localparam int W = 8;
  localparam int D = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] data_in = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         carry, zero, neg, stk_full, stk_empty, err;
  logic [2:0]   stk_count;

  acc_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .data_in   (data_in),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .stk_count (stk_count),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int cy;
    int cnt;
    int er;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int m_acc = 0;
  int m_cy  = 0;
  int m_err = 0;
  int m_stk[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cy  = 0;
    m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit e, input int o, input int d, input bit clr);
    bit   bad = 0;
    int   t;
    exp_t x;
    if (e) begin
      case (o)
        1: m_acc = d;
        2: begin m_acc = 0; m_cy = 0; end
        3: begin m_cy = (m_acc + 1) / M; m_acc = (m_acc + 1) % M; end
        4: begin m_cy = (m_acc == 0); m_acc = (m_acc + M - 1) % M; end
        5: begin m_cy = m_acc / (M / 2); m_acc = (m_acc * 2) % M; end
        6: begin m_cy = m_acc % 2; m_acc = m_acc / 2; end
        7: begin t = m_acc / (M / 2); m_cy = t; m_acc = (m_acc * 2) % M + t; end
        8: begin t = m_acc % 2; m_cy = t; m_acc = m_acc / 2 + t * (M / 2); end
        9: if (m_stk.size() == D) bad = 1; else m_stk.push_back(m_acc);
        10: if (m_stk.size() == 0) bad = 1; else m_acc = m_stk.pop_back();
        11: if (m_stk.size() == 0) bad = 1;
            else begin
              t = m_stk[m_stk.size()-1];
              m_stk[m_stk.size()-1] = m_acc;
              m_acc = t;
            end
        default: ;
      endcase
    end
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
    x.acc = m_acc;
    x.cy  = m_cy;
    x.cnt = m_stk.size();
    x.er  = m_err;
    exp_q.push_back(x);
  endtask

  // Drive one cycle's inputs on the falling edge and queue the expectation.
  task automatic step(input bit e, input int o, input int d, input bit clr);
    @(negedge clk);
    en      = e;
    op      = 4'(o);
    data_in = W'(d);
    err_clr = clr;
    model_step(e, o, d, clr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, int'(data_out), 0);
    chk({tag, "_carry"}, int'(carry), 0);
    chk({tag, "_zero"}, int'(zero), 1);
    chk({tag, "_count"}, int'(stk_count), 0);
    chk({tag, "_empty"}, int'(stk_empty), 1);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    err_clr = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a registered result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("data_out", int'(data_out), e.acc);
      chk("carry", int'(carry), e.cy);
      chk("zero", int'(zero), int'(e.acc == 0));
      chk("neg", int'(neg), e.acc / (M / 2));
      chk("stk_count", int'(stk_count), e.cnt);
      chk("stk_full", int'(stk_full), int'(e.cnt == D));
      chk("stk_empty", int'(stk_empty), int'(e.cnt == 0));
      chk("err", int'(err), e.er);
    end
  end

  initial begin
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Load and flags, then async reset mid-sequence
    step(1, 1, 8'h80, 0);
    idle();
    step(1, 3, 0, 0);
    mid_reset();

    // Inc/dec wrap
    step(1, 1, 8'hFF, 0);
    step(1, 3, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);

    // Shifts and rotates from 8'b1000_0001
    for (int k = 5; k <= 8; k++) begin
      step(1, 1, 8'h81, 0);
      step(1, k, 0, 0);
    end

    // Fill stack, overflow, drain
    step(1, 2, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 8'h11 * k, 0);
      step(1, 9, 0, 0);
    end
    step(1, 9, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 10, 0, 0);

    // Underflow, clear colliding with new error, clear alone
    step(1, 10, 0, 0);
    step(1, 10, 0, 1);
    step(0, 0, 0, 1);
    idle();

    // Swap, then pop, then disabled INC
    step(1, 1, 5, 0);
    step(1, 9, 0, 0);
    step(1, 1, 9, 0);
    step(1, 11, 0, 0);
    step(1, 10, 0, 0);
    step(0, 3, 0, 0);
    step(1, 11, 0, 0);
    step(1, 12, 0, 0);
    step(1, 15, 0, 0);

    // Random ops, biased toward stack traffic
    for (int i = 0; i < 3000; i++) begin
      int o;
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 11)) : int'($urandom_range(0, 15));
      step($urandom_range(0, 9) != 0, o, $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      if (i == 1500) mid_reset();
    end
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
